// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types, register field positions and hex segment table
package sevenseg_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic [1:0] {
    SEL_D0   = 2'b00,
    SEL_D1   = 2'b01,
    SEL_CTRL = 2'b10
  } sel_e;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_LZB_BIT = 1;
  localparam int CTRL_DP0_LSB = 4;
  localparam int CTRL_DP1_LSB = 8;

  // Only enable, blanking and the two dp masks are storage; the rest read back 0
  localparam logic [15:0] CTRL_RST  = 16'h0001;
  localparam logic [15:0] CTRL_MASK = 16'h0FF3;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit is replaced by the dp mask downstream
  localparam seg_t HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational nibble to active-low seven-segment code
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/sevenseg_display_ctrl.sv
// rtl/sevenseg_display_ctrl.sv - double-buffered dual 4-digit seven-segment scanner
module sevenseg_display_ctrl
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int GUARD       = 16
) (
  input  logic        i_mclk,
  input  logic        i_reset_n,
  input  logic        i_we,
  input  logic [1:0]  i_sel,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic [7:0]  D0_seg,
  output logic [3:0]  D0_a,
  output logic [7:0]  D1_seg,
  output logic [3:0]  D1_a
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   sh0_q, sh0_d, sh1_q, sh1_d;
  logic [15:0]   disp0_q, disp0_d, disp1_q, disp1_d;
  logic [15:0]   ctrl_q, ctrl_d;
  logic [7:0]    seg0_q, seg0_d, seg1_q, seg1_d;
  logic [3:0]    an0_q, an0_d, an1_q, an1_d;

  sel_e        sel;
  logic        wrap, frame, active, blank0, blank1;
  logic [15:0] sft0, sft1;
  logic [3:0]  an_on, dpm0, dpm1;
  seg_t        hex0, hex1;

  assign sel = sel_e'(i_sel);

  hex_to_7seg u_hex0 (.nibble_i(sft0[3:0]), .seg_o(hex0));
  hex_to_7seg u_hex1 (.nibble_i(sft1[3:0]), .seg_o(hex1));

  // Register readback returns shadows, not what is currently on the glass
  always_comb begin
    case (sel)
      SEL_D0:   o_rdata = sh0_q;
      SEL_D1:   o_rdata = sh1_q;
      SEL_CTRL: o_rdata = ctrl_q;
      default:  o_rdata = 16'h0000;
    endcase
  end

  // Scan timing, register writes and frame-boundary commit of shadows
  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    frame  = wrap && (idx_q == 2'd3);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    sh0_d  = (i_we && sel == SEL_D0) ? i_wdata : sh0_q;
    sh1_d  = (i_we && sel == SEL_D1) ? i_wdata : sh1_q;
    ctrl_d = (i_we && sel == SEL_CTRL) ? (i_wdata & CTRL_MASK) : ctrl_q;
    // Commit from the next-shadow so a write on the boundary edge is the one shown
    disp0_d = frame ? sh0_d : disp0_q;
    disp1_d = frame ? sh1_d : disp1_q;
  end

  // Per-slot pin values derived from the current counter, index and display data
  always_comb begin
    sft0   = disp0_q >> {idx_q, 2'b00};
    sft1   = disp1_q >> {idx_q, 2'b00};
    dpm0   = ctrl_q[CTRL_DP0_LSB +: 4];
    dpm1   = ctrl_q[CTRL_DP1_LSB +: 4];
    active = ctrl_q[CTRL_EN_BIT] && (cnt_q >= GUARD_C);
    // A digit is leading-zero when it and every more significant nibble are zero
    blank0 = ctrl_q[CTRL_LZB_BIT] && (idx_q != 2'd0) && (sft0 == 16'h0000);
    blank1 = ctrl_q[CTRL_LZB_BIT] && (idx_q != 2'd0) && (sft1 == 16'h0000);
    an_on  = ~(4'b0001 << idx_q);
    an0_d  = (active && !blank0) ? an_on : 4'hF;
    an1_d  = (active && !blank1) ? an_on : 4'hF;
    seg0_d = (active && !blank0) ? {~dpm0[idx_q], hex0[6:0]} : 8'hFF;
    seg1_d = (active && !blank1) ? {~dpm1[idx_q], hex1[6:0]} : 8'hFF;
  end

  // State and registered pins; reset blanks the displays without needing a clock
  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      sh0_q   <= 16'h0000;
      sh1_q   <= 16'h0000;
      disp0_q <= 16'h0000;
      disp1_q <= 16'h0000;
      ctrl_q  <= CTRL_RST;
      seg0_q  <= 8'hFF;
      seg1_q  <= 8'hFF;
      an0_q   <= 4'hF;
      an1_q   <= 4'hF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      disp0_q <= disp0_d;
      disp1_q <= disp1_d;
      ctrl_q  <= ctrl_d;
      seg0_q  <= seg0_d;
      seg1_q  <= seg1_d;
      an0_q   <= an0_d;
      an1_q   <= an1_d;
    end
  end

  assign D0_seg = seg0_q;
  assign D1_seg = seg1_q;
  assign D0_a   = an0_q;
  assign D1_a   = an1_q;

endmodule

// File: tb/tb_sevenseg_display_ctrl.sv
// tb/tb_sevenseg_display_ctrl.sv - randomized and directed bench for sevenseg_display_ctrl
module tb_sevenseg_display_ctrl;

  logic        i_mclk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_sel = 2'b00;
  logic [15:0] i_wdata = 16'h0000;
  logic [15:0] o_rdata;
  logic [7:0]  D0_seg, D1_seg;
  logic [3:0]  D0_a, D1_a;

  sevenseg_display_ctrl #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .i_mclk(i_mclk), .i_reset_n(i_reset_n), .i_we(i_we), .i_sel(i_sel),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .D0_seg(D0_seg), .D0_a(D0_a),
    .D1_seg(D1_seg), .D1_a(D1_a)
  );

  always #5 i_mclk = ~i_mclk;

  int vec = 0;
  int errs = 0;

  // Model: time since reset release, register contents, expected pins
  int          t;
  logic [15:0] sh0, sh1, dp0, dp1, ctl;
  logic [3:0]  ea0, ea1;
  logic [7:0]  es0, es1;
  logic [15:0] erd;
  logic [7:0]  seen0 [4];
  logic [7:0]  seen1 [4];
  logic        d1_hi_lit;
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [11:0] exp_pin(input logic [15:0] disp, input logic [3:0] mask, input int tt);
    int cnt, idx;
    logic [7:0] seg;
    logic [3:0] an;
    cnt = tt % 8;
    idx = (tt / 8) % 4;
    if (!ctl[0] || cnt < 2) return {4'hF, 8'hFF};
    if (ctl[1] && idx > 0 && (disp >> (4 * idx)) == 16'h0) return {4'hF, 8'hFF};
    seg    = hex_tab[(disp >> (4 * idx)) & 16'hF];
    seg[7] = ~mask[idx];
    an     = 4'hF & ~(4'b0001 << idx);
    return {an, seg};
  endfunction

  task automatic model_reset();
    t = 0; sh0 = 0; sh1 = 0; dp0 = 0; dp1 = 0; ctl = 16'h0001;
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 4; k++) begin seen0[k] = 8'hxx; seen1[k] = 8'hxx; end
    d1_hi_lit = 1'b0;
  endtask

  // One clock: drive inputs, advance model across the edge, settle outputs
  task automatic step(input logic we, input logic [1:0] sel, input logic [15:0] wd);
    logic [11:0] p0, p1;
    i_we = we; i_sel = sel; i_wdata = wd;
    @(posedge i_mclk);
    p0 = exp_pin(dp0, ctl[7:4], t);
    p1 = exp_pin(dp1, ctl[11:8], t);
    if (we) begin
      if (sel == 2'd0) sh0 = wd;
      else if (sel == 2'd1) sh1 = wd;
      else if (sel == 2'd2) ctl = wd & 16'h0FF3;
    end
    if (t % 32 == 31) begin dp0 = sh0; dp1 = sh1; end
    t++;
    {ea0, es0} = p0;
    {ea1, es1} = p1;
    erd = (sel == 2'd0) ? sh0 : (sel == 2'd1) ? sh1 : (sel == 2'd2) ? ctl : 16'h0;
    #1;
    i_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (D0_a == ~(4'b0001 << k)) seen0[k] = D0_seg;
      if (D1_a == ~(4'b0001 << k)) seen1[k] = D1_seg;
    end
    if (D1_a[3] == 1'b0 || D1_a[2] == 1'b0) d1_hi_lit = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_mclk);
    #1;
    vec++;
    if ({D0_a, D0_seg, D1_a, D1_seg} !== {4'hF, 8'hFF, 4'hF, 8'hFF}) begin
      errs++; $display("FAIL reset_pins got %h required %h", {D0_a, D0_seg, D1_a, D1_seg}, 24'hFFFFFF);
    end
    i_sel = 2'd2; #1;
    vec++;
    if (o_rdata !== 16'h0001) begin errs++; $display("FAIL reset_ctrl got %h required 0001", o_rdata); end
    i_sel = 2'd0; #1;
    vec++;
    if (o_rdata !== 16'h0000) begin errs++; $display("FAIL reset_d0 got %h required 0000", o_rdata); end
    @(negedge i_mclk);
    i_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_scan_start();
    repeat (3) begin
      step(1'b0, 2'd0, 16'h0);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL scan_start t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
    end
    vec++;
    if ({D0_a, D0_seg} !== {4'b1110, 8'hC0}) begin
      errs++; $display("FAIL first_digit got %h required %h", {D0_a, D0_seg}, 12'hEC0);
    end
  endtask

  task automatic test_write_commit();
    step(1'b1, 2'd0, 16'h1234);
    vec++;
    if (o_rdata !== 16'h1234) begin errs++; $display("FAIL shadow_read got %h required 1234", o_rdata); end
    while (t % 32 != 0 || t < 64) begin
      step(1'b0, 2'd0, 16'h0);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL pre_commit t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
    end
    clear_seen();
    repeat (32) begin
      step(1'b0, 2'd0, 16'h0);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL commit_frame t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
    end
    vec++;
    if ({seen0[3], seen0[2], seen0[1], seen0[0]} !== 32'hF9A4B099) begin
      errs++; $display("FAIL d0_digits got %h required F9A4B099", {seen0[3], seen0[2], seen0[1], seen0[0]});
    end
  endtask

  task automatic test_lzb();
    step(1'b1, 2'd2, 16'h0003);
    vec++;
    if (o_rdata !== 16'h0003) begin errs++; $display("FAIL ctrl_read got %h required 0003", o_rdata); end
    step(1'b1, 2'd1, 16'h0050);
    while (t % 32 != 0) step(1'b0, 2'd1, 16'h0);
    clear_seen();
    repeat (32) begin
      step(1'b0, 2'd1, 16'h0);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL lzb_frame t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
    end
    vec++;
    if ({d1_hi_lit, seen1[1], seen1[0]} !== {1'b0, 8'h92, 8'hC0}) begin
      errs++; $display("FAIL lzb_digits got %h required %h", {d1_hi_lit, seen1[1], seen1[0]}, {1'b0, 8'h92, 8'hC0});
    end
  endtask

  task automatic test_dp();
    step(1'b1, 2'd2, 16'h0041);
    repeat (32) begin
      step(1'b0, 2'd2, 16'h0);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL dp_frame t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
      if (D0_a != 4'hF) begin
        vec++;
        if (D0_seg[7] !== (D0_a != 4'b1011)) begin
          errs++; $display("FAIL dp_bit an=%b got %b required %b", D0_a, D0_seg[7], D0_a != 4'b1011);
        end
      end
    end
  endtask

  task automatic test_boundary_write();
    step(1'b1, 2'd2, 16'h0001);
    while (t % 32 != 31) step(1'b0, 2'd0, 16'h0);
    step(1'b1, 2'd0, 16'hABCD);
    clear_seen();
    repeat (32) begin
      step(1'b0, 2'd0, 16'h0);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL boundary_frame t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
    end
    vec++;
    if (seen0[0] !== 8'hA1) begin errs++; $display("FAIL boundary_commit got %h required A1", seen0[0]); end
  endtask

  task automatic test_random();
    logic        we;
    logic [1:0]  sel;
    logic [15:0] wd;
    repeat (600) begin
      we  = ($urandom_range(0, 5) == 0);
      sel = 2'($urandom_range(0, 3));
      wd  = 16'($urandom);
      if (sel == 2'd0 || sel == 2'd1) wd = wd & {{4{wd[15]}}, {4{wd[14]}}, 8'hFF};
      if (sel == 2'd2) wd[0] = ($urandom_range(0, 3) != 0);
      step(we, sel, wd);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL random t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 2'd2, 16'h0001);
    while (t % 8 != 5) step(1'b0, 2'd0, 16'h0);
    #2;
    i_reset_n = 1'b0;
    #1;
    vec++;
    if ({D0_a, D0_seg, D1_a, D1_seg} !== {4'hF, 8'hFF, 4'hF, 8'hFF}) begin
      errs++; $display("FAIL async_reset got %h required FFFFFF", {D0_a, D0_seg, D1_a, D1_seg});
    end
    #1;
    i_reset_n = 1'b1;
    model_reset();
    repeat (12) begin
      step(1'b0, 2'd0, 16'h0);
      vec++;
      if ({D0_a, D0_seg, D1_a, D1_seg, o_rdata} !== {ea0, es0, ea1, es1, erd}) begin
        errs++; $display("FAIL restart t=%0d got %h required %h", t, {D0_a, D0_seg, D1_a, D1_seg, o_rdata}, {ea0, es0, ea1, es1, erd});
      end
      if (t == 3) begin
        vec++;
        if ({D0_a, D0_seg} !== {4'b1110, 8'hC0}) begin
          errs++; $display("FAIL restart_digit0 got %h required EC0", {D0_a, D0_seg});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    clear_seen();
    test_reset();
    test_scan_start();
    test_write_commit();
    test_lzb();
    test_dp();
    test_boundary_write();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
